// File: rtl/fbmem_loader_ram.sv
// Boot-time data memory for the FB-CPU: zero-fills itself, takes a program image
// over a valid/ready loader port, then serves the CPU RAM bus until the next reset.
//
// state | meaning
// CLEAR | sweep writes 0 to every word, CPU held
// LOAD  | loader port open, CPU held
// RUN   | CPU bus active, loader ignored (terminal)
module fbmem_loader_ram #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int DEPTH         = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [ADDRESS_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]    i_ram_data_in,
  output logic [DATA_WIDTH-1:0]    o_ram_data_out,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  input  logic                     ld_last,
  output logic                     o_cpu_hold,
  output logic [ADDRESS_WIDTH:0]   o_load_count
);

  localparam int CNT_W = ADDRESS_WIDTH + 1;
  localparam logic [CNT_W-1:0]         CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]         DEPTH_W  = CNT_W'(DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] CLR_LAST = ADDRESS_WIDTH'(DEPTH - 1);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];

  logic [1:0]               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [CNT_W-1:0]         load_cnt_q, load_cnt_d;
  logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;

  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0]    mem_wdata;

  logic cpu_addr_ok;
  logic ld_addr_ok;

  assign cpu_addr_ok = {1'b0, i_addr} < DEPTH_W;
  assign ld_addr_ok  = {1'b0, ld_addr} < DEPTH_W;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    load_cnt_d = load_cnt_q;
    rd_data_d  = '0;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ld_valid) begin
          if (load_cnt_q != CNT_MAX) load_cnt_d = load_cnt_q + 1'b1;
          if (ld_last) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Read-first: sample the array before this edge's write lands.
        if (cpu_addr_ok) rd_data_d = mem_q[i_addr];
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_cnt_q;
    mem_wdata = '0;
    case (state_q)
      ST_CLEAR: mem_we = 1'b1;
      ST_LOAD: begin
        if (ld_valid && ld_addr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = ld_addr;
          mem_wdata = ld_data;
        end
      end
      ST_RUN: begin
        if (i_we && cpu_addr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = i_addr;
          mem_wdata = i_ram_data_in;
        end
      end
      default: mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      load_cnt_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      load_cnt_q <= load_cnt_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Array has no reset; the CLEAR sweep is its only initialisation.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign ld_ready       = (state_q == ST_LOAD);
  assign o_cpu_hold     = (state_q != ST_RUN);
  assign o_load_count   = load_cnt_q;
  assign o_ram_data_out = rd_data_q;

endmodule
